// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills IF/ID, handles stall/flush and
// parks in FAULT on a misaligned redirect. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [63:0] Branch_Target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    output logic        Fetch_Fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Flush_Count
`endif
);

    typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_ins;
    logic        r_ifid_vld;
    logic        r_fault;

    // Memory address comes straight off the PC flop.
    assign Inst_Address     = r_pc;
    assign IFID_PC          = r_ifid_pc;
    assign IFID_Instruction = r_ifid_ins;
    assign IFID_Valid       = r_ifid_vld;
    assign Fetch_Fault      = r_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_ifid_pc  <= 64'h0;
            r_ifid_ins <= NOP_INSN;
            r_ifid_vld <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // Redirect outranks a hazard hold in the same cycle.
                    if (Flush) begin
                        r_ifid_pc  <= 64'h0;
                        r_ifid_ins <= NOP_INSN;
                        r_ifid_vld <= 1'b0;
                        if (Branch_Target[1:0] == 2'b00) begin
                            r_pc <= Branch_Target;
                        end else begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    end else if (!Stall) begin
                        r_ifid_pc  <= r_pc;
                        r_ifid_ins <= Instruction;
                        r_ifid_vld <= 1'b1;
                        r_pc       <= r_pc + 64'd4;
                    end
                end
                S_FAULT: begin
                    r_ifid_pc  <= 64'h0;
                    r_ifid_ins <= NOP_INSN;
                    r_ifid_vld <= 1'b0;
                    r_fault    <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_load;
    logic        w_flush_acc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    assign w_load      = (r_state == S_RUN) && !Flush && !Stall;
    assign w_flush_acc = (r_state == S_RUN) && Flush;
    assign Fetch_Count = r_fetch_cnt;
    assign Flush_Count = r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_load)      r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_flush_acc) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a main instance driven through directed
// cycles, plus a second instance with RESET_PC at the top of the address space.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [63:0] Branch_Target = 64'h0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address, IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid, Fetch_Fault;

    logic [31:0] w_ins2;
    logic [63:0] w_addr2, w_pc2;
    logic [31:0] w_iins2;
    logic        w_vld2, w_fault2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_Count, Flush_Count, w_fc2, w_flc2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        case (a)
            64'h0:   memf = 32'h00400193;
            64'h4:   memf = 32'h00318193;
            64'h8:   memf = 32'h00300233;
            default: memf = 32'hC0DE0000 ^ a[31:0];
        endcase
    endfunction

    assign Instruction = memf(Inst_Address);
    assign w_ins2      = memf(w_addr2);

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .Stall(Stall), .Flush(Flush),
        .Branch_Target(Branch_Target), .Instruction(Instruction),
        .Inst_Address(Inst_Address), .IFID_PC(IFID_PC),
        .IFID_Instruction(IFID_Instruction), .IFID_Valid(IFID_Valid),
        .Fetch_Fault(Fetch_Fault)
`ifdef FETCH_PERF_CNT_EN
        , .Fetch_Count(Fetch_Count), .Flush_Count(Flush_Count)
`endif
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .Stall(1'b0), .Flush(1'b0),
        .Branch_Target(64'h0), .Instruction(w_ins2),
        .Inst_Address(w_addr2), .IFID_PC(w_pc2),
        .IFID_Instruction(w_iins2), .IFID_Valid(w_vld2),
        .Fetch_Fault(w_fault2)
`ifdef FETCH_PERF_CNT_EN
        , .Fetch_Count(w_fc2), .Flush_Count(w_flc2)
`endif
    );

    typedef struct {
        logic        sel;
        string       name;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        v;
        logic        f;
        logic [31:0] fc;
        logic [31:0] flc;
    } exp_t;

    exp_t q[$];

    int          efc = 0;
    int          efl = 0;
    logic        tb_fault = 1'b0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    // Monitor: after each rising edge, pop and compare every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (!e.sel) begin
                    chk({e.name, ".addr"},  Inst_Address, e.addr);
                    chk({e.name, ".pc"},    IFID_PC, e.pc);
                    chk({e.name, ".ins"},   {32'h0, IFID_Instruction}, {32'h0, e.ins});
                    chk({e.name, ".valid"}, {63'h0, IFID_Valid}, {63'h0, e.v});
                    chk({e.name, ".fault"}, {63'h0, Fetch_Fault}, {63'h0, e.f});
`ifdef FETCH_PERF_CNT_EN
                    chk({e.name, ".fcnt"},  {32'h0, Fetch_Count}, {32'h0, e.fc});
                    chk({e.name, ".flcnt"}, {32'h0, Flush_Count}, {32'h0, e.flc});
`endif
                end else begin
                    chk({e.name, ".addr"},  w_addr2, e.addr);
                    chk({e.name, ".pc"},    w_pc2, e.pc);
                    chk({e.name, ".ins"},   {32'h0, w_iins2}, {32'h0, e.ins});
                    chk({e.name, ".valid"}, {63'h0, w_vld2}, {63'h0, e.v});
                    chk({e.name, ".fault"}, {63'h0, w_fault2}, {63'h0, e.f});
                end
            end
        end
    end

    // Drive one cycle of stimulus at the falling edge and queue the state
    // expected after the following rising edge.
    task automatic cyc(input string n, input logic rst, input logic st, input logic fl,
                       input logic [63:0] tgt, input logic [63:0] ea, input logic [63:0] epc,
                       input logic [31:0] ei, input logic ev, input logic ef);
        exp_t e;
        @(negedge clk);
        reset_n = rst; Stall = st; Flush = fl; Branch_Target = tgt;
        if (!rst) begin
            efc = 0; efl = 0;
        end else if (!tb_fault) begin
            if (fl) efl++;
            else if (!st) efc++;
        end
        tb_fault = ef;
        e.sel = 1'b0; e.name = n; e.addr = ea; e.pc = epc; e.ins = ei;
        e.v = ev; e.f = ef; e.fc = efc; e.flc = efl;
        q.push_back(e);
    endtask

    task automatic wexp(input string n, input logic [63:0] ea, input logic [63:0] epc,
                        input logic [31:0] ei, input logic ev);
        exp_t e;
        e.sel = 1'b1; e.name = n; e.addr = ea; e.pc = epc; e.ins = ei;
        e.v = ev; e.f = 1'b0; e.fc = 0; e.flc = 0;
        q.push_back(e);
    endtask

    initial begin
        cyc("reset", 0, 0, 0, 0, 64'h0, 64'h0, NOP, 0, 0);
        wexp("wrap_reset", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 0);

        cyc("fetch0", 1, 0, 0, 0, 64'h4, 64'h0, 32'h00400193, 1, 0);
        wexp("wrap_fetch0", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h3F21FFFC, 1);

        cyc("stall0", 1, 1, 0, 0, 64'h4, 64'h0, 32'h00400193, 1, 0);
        wexp("wrap_fetch1", 64'h4, 64'h0, 32'h00400193, 1);
        cyc("stall1", 1, 1, 0, 0, 64'h4, 64'h0, 32'h00400193, 1, 0);
        cyc("stall2", 1, 1, 0, 0, 64'h4, 64'h0, 32'h00400193, 1, 0);

        cyc("fetch4", 1, 0, 0, 0, 64'h8, 64'h4, 32'h00318193, 1, 0);
        cyc("fetch8", 1, 0, 0, 0, 64'hC, 64'h8, 32'h00300233, 1, 0);

        cyc("flush40", 1, 0, 1, 64'h40, 64'h40, 64'h0, NOP, 0, 0);
        cyc("fetch40", 1, 0, 0, 0, 64'h44, 64'h40, 32'hC0DE0040, 1, 0);

        cyc("flush_stall20", 1, 1, 1, 64'h20, 64'h20, 64'h0, NOP, 0, 0);
        cyc("stall_bubble", 1, 1, 0, 0, 64'h20, 64'h0, NOP, 0, 0);
        cyc("fetch20", 1, 0, 0, 0, 64'h24, 64'h20, 32'hC0DE0020, 1, 0);
        cyc("fetch24", 1, 0, 0, 0, 64'h28, 64'h24, 32'hC0DE0024, 1, 0);

        cyc("misalign22", 1, 0, 1, 64'h22, 64'h28, 64'h0, NOP, 0, 1);
        for (int i = 0; i < 10; i++)
            cyc("fault_hold", 1, i[0], (i % 3) == 0, (i % 2 == 1) ? 64'h80 : 64'h22,
                64'h28, 64'h0, NOP, 0, 1);

        cyc("reset_mid", 0, 0, 0, 0, 64'h0, 64'h0, NOP, 0, 0);
        cyc("refetch0", 1, 0, 0, 0, 64'h4, 64'h0, 32'h00400193, 1, 0);
        cyc("refetch4", 1, 0, 0, 0, 64'h8, 64'h4, 32'h00318193, 1, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter and drives `Inst_Address` to the combinational instruction memory. It captures the returned 32-bit `Instruction` into the IF/ID pipeline register, and it applies hazard-unit stalls and branch-redirect flushes. It also detects misaligned redirect targets and parks the front end in a fault state.

## Interface
Parameters:
- `RESET_PC`, default `64'h0`: PC value loaded on reset.
- `NOP_INSN`, default `32'h00000013`: bubble encoding (`addi x0,x0,0`) inserted into IF/ID.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  hazard-unit hold of PC and IF/ID.
- `Flush`  in  1  branch/jump resolved taken; redirect the PC.
- `Branch_Target`  in  64  redirect address, sampled when `Flush`=1.
- `Instruction`  in  32  instruction word from instruction memory, combinational on `Inst_Address`.
- `Inst_Address`  out  64  current PC to instruction memory.
- `IFID_PC`  out  64  PC of the instruction held in IF/ID.
- `IFID_Instruction`  out  32  instruction held in IF/ID.
- `IFID_Valid`  out  1  IF/ID holds a real instruction.
- `Fetch_Fault`  out  1  sticky misaligned-redirect flag.
- `Fetch_Count`, `Flush_Count`  out  32 each  exist only with `FETCH_PERF_CNT_EN`.

## Operation
FSM states:
- `RUN`:
  - Normal fetch.
  - `Flush`=1 with `Branch_Target[1:0]`≠0 moves to `FAULT`.
- `FAULT`:
  - Absorbing state; exits only on reset.
  - PC frozen, IF/ID holds the bubble, `Fetch_Fault`=1.
  - `Stall` and `Flush` are ignored.

Per-cycle priority in `RUN`, highest first:
- **Flush, aligned target:** PC ← `Branch_Target`; IF/ID ← {PC=0, `NOP_INSN`, Valid=0}.
- **Flush, misaligned target:** PC holds; IF/ID ← bubble; state ← `FAULT`.
- **Stall (no Flush):** PC and all IF/ID fields hold their values.
- **Otherwise:** IF/ID ← {PC, `Instruction`, 1}; PC ← PC+4.

Flush beats Stall: a branch redirect always wins over a load-use hold in the same cycle.

Arithmetic:
- PC increment is modulo 2^64; `64'hFFFF_FFFF_FFFF_FFFC`+4 = 0 with no flag.
- `Branch_Target` is used verbatim; no alignment masking.
- `Inst_Address` is the PC register output itself; no combinational logic is added on the memory path.

## Timing
Reset values, applied asynchronously while `reset_n`=0:
- PC = `RESET_PC`; `Inst_Address` = `RESET_PC`.
- `IFID_PC`=0, `IFID_Instruction`=`NOP_INSN`, `IFID_Valid`=0.
- `Fetch_Fault`=0, state=`RUN`.
- Counters=0.

Latency:
- First rising edge after `reset_n` deasserts captures the instruction at `RESET_PC`; `IFID_Valid`=1 from that edge.
- Fetch latency is one cycle: address presented in cycle N, instruction visible on IF/ID outputs after edge N+1.
- Redirect: `Flush` sampled at edge N → IF/ID bubble and PC=target after N; target instruction valid in IF/ID after N+1.

Stall behaviour:
- Any stall length holds `Inst_Address` constant.
- No instruction is lost or duplicated across the stall.

Reset mid-operation:
- Takes effect immediately, asynchronously.
- Clears `FAULT` and discards any pending IF/ID contents.

## Configuration
`FETCH_PERF_CNT_EN`:
- **Defined:**
  - `Fetch_Count` increments on every edge where IF/ID loads with Valid=1.
  - `Flush_Count` increments on every accepted `Flush` in `RUN`, aligned or not.
  - Both are 32-bit, wrap silently, and reset to 0.
- **Undefined:**
  - Neither port nor counter logic exists.
  - All other behaviour is identical.

## Test plan
- **Reset/sequential fetch.** Memory holds 0x00400193, 0x00318193, 0x00300233 at 0/4/8; release reset, no Stall/Flush.
  - Expect IF/ID to show (PC 0, 0x00400193), then (4, 0x00318193), then (8, 0x00300233), with Valid=1 each cycle.
  - Expect `Inst_Address` 0→4→8→12.
- **Stall.** Assert `Stall` for 3 cycles while PC=4.
  - Expect `Inst_Address`=4 and IF/ID=(0, 0x00400193) held throughout.
  - After release, expect IF/ID=(4, 0x00318193).
- **Flush.** `Flush`=1, `Branch_Target`=0x40 at PC=8.
  - Next cycle: Valid=0, `IFID_Instruction`=0x00000013, `Inst_Address`=0x40.
  - Following cycle: `IFID_PC`=0x40, Valid=1.
- **Flush+Stall.** Both asserted, target 0x20: flush wins; PC=0x20, bubble inserted.
- **Misaligned target.** `Flush` with target 0x22.
  - Expect `Fetch_Fault`=1 and PC frozen.
  - Valid stays 0 for 10 cycles despite further Flush/Stall.
  - Asserting `reset_n`=0 clears the fault.
- **Wrap and counters.** `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC: expect the next `Inst_Address`=0.
  - With `FETCH_PERF_CNT_EN`, 5 fetches plus 2 flushes yield `Fetch_Count`=5, `Flush_Count`=2.
